decode_stage_param: RTL and testbench
=====================================

Name: decode_stage_param

Overview:
Parametrised decode stage for the pipelined RISC-V core. It reads the register file, extends the immediate and registers all decode results into the ID/EX pipeline register. Compared with the previous decode stage it adds:
- configurable XLEN and register count
- U- and J-type immediates
- an EX-stage stall (hold) input
- a valid bit that tracks bubbles
- optional write-through bypass from writeback
It sits between the fetch/IF-ID register and the execute stage, and receives the writeback port from the W stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
NREGS, 32, number of architectural registers; power of two, 16 or 32.
RAW, $clog2(NREGS), register address width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
StallE  in  1  hold ID/EX register contents
FlushE  in  1  clear ID/EX register to a bubble
ValidD  in  1  instruction in decode is valid
InstrD  in  32  instruction word
PCD  in  XLEN  PC of decode instruction
PCPlus4D  in  XLEN  PC+4 of decode instruction
ImmSrcD  in  3  immediate select (decode_pkg::imm_src_t)
RegWriteW  in  1  writeback enable
RdW  in  RAW  writeback destination
ResultW  in  XLEN  writeback data
RD1_E, RD2_E  out  XLEN  registered source operands
ImmExtE  out  XLEN  registered extended immediate
Rs1E, Rs2E, RdE  out  RAW  registered register indices
PCE, PCPlus4E  out  XLEN  registered PCs
ValidE  out  1  ID/EX entry valid

Behaviour:
- Field extraction: Rs1D=InstrD[15+:RAW], Rs2D=InstrD[20+:RAW], RdD=InstrD[7+:RAW]. With NREGS=16 the MSB of each field is ignored.
- Register file:
  - NREGS x XLEN; write on rising clk when RegWriteW && RdW!=0.
  - Reads are combinational; register 0 always reads 0.
  - rst clears all entries to 0 in the same cycle.
- Immediate encoding, sign-extended to XLEN from InstrD[31]:
  - I=0: [31:20]
  - S=1: {[31:25],[11:7]}
  - B=2: {[31],[7],[30:25],[11:8],0}
  - J=3: {[31],[19:12],[20],[30:21],0}
  - U=4: {[31:12],12'b0}
  - Codes 5-7 give 0.
- ID/EX register update priority per rising edge: rst > FlushE > StallE > load.
  - rst or FlushE: every output goes to 0, including ValidE=0.
  - StallE: all outputs hold.
  - Load: outputs take the D-side values; ValidE=ValidD.
- FlushE and StallE both high: flush wins.
- Reset values: all outputs 0; regfile all 0.
- Latency:
  - D inputs appear on the E outputs 1 cycle later.
  - A regfile write is visible to a later D-stage read next cycle, or in the same cycle if bypass is enabled.
- Writeback to register 0 is ignored, and the bypass never fires for register 0.
- rst asserted mid-stall: register is cleared, and StallE is ignored while rst is high.
- Register file writes continue during StallE and FlushE.

Optional Feature:
DECODE_WB_BYPASS_EN.
- Defined: if RegWriteW && RdW!=0 && RdW==Rs1D (resp. Rs2D), RD1_D (resp. RD2_D) takes ResultW in the same cycle. Write-then-read in one cycle therefore captures the new value into RD1_E/RD2_E.
- Undefined: the read returns the pre-write register contents. The hazard unit must stall one extra cycle for a writeback-to-decode dependency.

Decomposition:
- Package decode_pkg holds:
  - imm_src_t enum: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, 3 bits
  - XLEN_DEFAULT=32 and NREGS_DEFAULT=32
  - an idex_t packed struct of the E-stage fields, parametrised via localparams
- One sub-module, regfile_param (#XLEN, #NREGS), containing the storage, synchronous clear, x0 handling and the optional bypass mux.
- Immediate extension stays as an inline function in decode_pkg (imm_extend).

Test Plan:
1. Reset then load: rst 1 cycle. Drive InstrD=0x00500093 (addi x1,x0,5), ImmSrcD=I, ValidD=1, PCD=0x100 -> next cycle ImmExtE=5, RdE=1, Rs1E=0, RD1_E=0, PCE=0x100, ValidE=1.
2. Immediates: InstrD=0xFE000EE3 with ImmSrcD=B -> ImmExtE=0xFFFFFFFC (B, -4). InstrD=0x123450B7 with ImmSrcD=U -> ImmExtE=0x12345000.
3. Write/read:
   - RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, with decode reading rs1=3 in the same cycle.
   - With bypass: RD1_E=0xDEADBEEF.
   - Without bypass: RD1_E=old value (0), and a read one cycle later gives 0xDEADBEEF.
4. x0 protection: RegWriteW=1, RdW=0, ResultW=0xFFFFFFFF, then read rs1=0 -> RD1_E=0 in all configurations.
5. Stall/flush:
   - Load PCD=0x200, then StallE=1 for 3 cycles while PCD changes -> PCE stays 0x200.
   - Then FlushE=1 and StallE=1 together -> all outputs 0, ValidE=0.
6. Parameter sweep: XLEN=64, NREGS=16. Write x15=0x8000_0000_0000_0001 and read it back -> RD2_E equal. I-imm 0x800 sign-extends to 0xFFFF_FFFF_FFFF_F800.

Source files
------------

// File: rtl/decode_stage_param_pkg.sv
// decode_pkg: shared types and helpers for the parametrised decode stage.
// Holds the immediate-select encoding, default datapath sizes, the
// default-width ID/EX record and the immediate extender.
package decode_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int RAW_DEFAULT   = $clog2(NREGS_DEFAULT);

    // Widest legal datapath; imm_extend produces this width and callers narrow it.
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    // ID/EX record for the default core configuration.
    typedef struct packed {
        logic                    valid;
        logic [XLEN_DEFAULT-1:0] rd1;
        logic [XLEN_DEFAULT-1:0] rd2;
        logic [XLEN_DEFAULT-1:0] immExt;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pcPlus4;
        logic [RAW_DEFAULT-1:0]  rs1;
        logic [RAW_DEFAULT-1:0]  rs2;
        logic [RAW_DEFAULT-1:0]  rd;
    } idex_t;

    // Sign-extended immediate at full width; truncating it to a narrower
    // XLEN still yields the correctly sign-extended value. Unused codes give 0.
    function automatic logic [XLEN_MAX-1:0] imm_extend(input logic [31:0] ins,
                                                        input imm_src_t    src);
        case (src)
            IMM_I:   imm_extend = {{52{ins[31]}}, ins[31:20]};
            IMM_S:   imm_extend = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_extend = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   imm_extend = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   imm_extend = {{32{ins[31]}}, ins[31:12], 12'b0};
            default: imm_extend = '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_param_if.sv
// decode_stage_param_if: bundles the decode-side inputs, the writeback port
// and the registered ID/EX outputs of the decode stage.
// master = upstream/hazard/writeback side, slave = the decode stage itself.
interface decode_stage_param_if
    import decode_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEFAULT,
    parameter int  NREGS = NREGS_DEFAULT,
    localparam int RAW   = $clog2(NREGS)
);

    logic            StallE;
    logic            FlushE;
    logic            ValidD;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    imm_src_t        ImmSrcD;

    logic            RegWriteW;
    logic [RAW-1:0]  RdW;
    logic [XLEN-1:0] ResultW;

    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] ImmExtE;
    logic [RAW-1:0]  Rs1E;
    logic [RAW-1:0]  Rs2E;
    logic [RAW-1:0]  RdE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic            ValidE;

    modport master (
        output StallE, FlushE, ValidD, InstrD, PCD, PCPlus4D, ImmSrcD,
        output RegWriteW, RdW, ResultW,
        input  RD1_E, RD2_E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ValidE
    );

    modport slave (
        input  StallE, FlushE, ValidD, InstrD, PCD, PCPlus4D, ImmSrcD,
        input  RegWriteW, RdW, ResultW,
        output RD1_E, RD2_E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E, ValidE
    );

endinterface

// File: rtl/decode_stage_param_regfile.sv
// regfile_param: NREGS x XLEN architectural register file with two
// combinational read ports and one write port. x0 always reads as zero.
// Optional feature macro: DECODE_WB_BYPASS_EN -- when defined, a write in
// flight is forwarded to a matching read port in the same cycle.
module regfile_param #(
    parameter int  XLEN  = 32,
    parameter int  NREGS = 32,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [RAW-1:0]  i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [RAW-1:0]  i_raddr1,
    input  logic [RAW-1:0]  i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wrEn;

    // Writes to x0 are dropped so the bypass and the storage agree on x0.
    assign w_wrEn = i_we && (i_waddr != '0);

    // Storage: synchronous clear of every entry, otherwise a single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: x0 forced to zero, optional same-cycle forwarding of the write.
    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef DECODE_WB_BYPASS_EN
        if (w_wrEn && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
        if (w_wrEn && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
`endif
    end

endmodule

// File: rtl/decode_stage_param.sv
// decode_stage_param: parametrised RISC-V decode stage. Extracts register
// fields, reads the register file, extends the immediate and captures the
// results in the ID/EX register with flush/stall control and a valid bit.
// Optional feature macro: DECODE_WB_BYPASS_EN (write-through bypass from
// writeback, implemented inside regfile_param).
module decode_stage_param
    import decode_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEFAULT,
    parameter int  NREGS = NREGS_DEFAULT,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic clk,
    input  logic rst,
    decode_stage_param_if.slave bus
);

    // ID/EX record at this instance's widths.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immExt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
    } idex_e_t;

    logic [RAW-1:0]  w_rs1D;
    logic [RAW-1:0]  w_rs2D;
    logic [RAW-1:0]  w_rdD;
    logic [XLEN-1:0] w_rd1D;
    logic [XLEN-1:0] w_rd2D;
    logic [XLEN-1:0] w_immExtD;
    idex_e_t         w_idexD;
    idex_e_t         r_idex;

    // With 16 registers the top bit of each 5-bit field is simply not selected.
    assign w_rs1D    = bus.InstrD[15 +: RAW];
    assign w_rs2D    = bus.InstrD[20 +: RAW];
    assign w_rdD     = bus.InstrD[7  +: RAW];
    assign w_immExtD = XLEN'(imm_extend(bus.InstrD, bus.ImmSrcD));

    regfile_param #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.RegWriteW),
        .i_waddr  (bus.RdW),
        .i_wdata  (bus.ResultW),
        .i_raddr1 (w_rs1D),
        .i_raddr2 (w_rs2D),
        .o_rdata1 (w_rd1D),
        .o_rdata2 (w_rd2D)
    );

    // Assemble the decode-side record that a load cycle captures.
    always_comb begin
        w_idexD         = '0;
        w_idexD.valid   = bus.ValidD;
        w_idexD.rd1     = w_rd1D;
        w_idexD.rd2     = w_rd2D;
        w_idexD.immExt  = w_immExtD;
        w_idexD.pc      = bus.PCD;
        w_idexD.pcPlus4 = bus.PCPlus4D;
        w_idexD.rs1     = w_rs1D;
        w_idexD.rs2     = w_rs2D;
        w_idexD.rd      = w_rdD;
    end

    // ID/EX register: reset and flush clear to a bubble and beat stall, stall holds.
    always_ff @(posedge clk) begin
        if (rst || bus.FlushE) begin
            r_idex <= '0;
        end else if (!bus.StallE) begin
            r_idex <= w_idexD;
        end
    end

    assign bus.ValidE   = r_idex.valid;
    assign bus.RD1_E    = r_idex.rd1;
    assign bus.RD2_E    = r_idex.rd2;
    assign bus.ImmExtE  = r_idex.immExt;
    assign bus.PCE      = r_idex.pc;
    assign bus.PCPlus4E = r_idex.pcPlus4;
    assign bus.Rs1E     = r_idex.rs1;
    assign bus.Rs2E     = r_idex.rs2;
    assign bus.RdE      = r_idex.rd;

endmodule

// File: tb/tb_decode_stage_param.sv
// tb_decode_stage_param: scoreboard bench for decode_stage_param.
// Two instances: default (XLEN=32, NREGS=32) and wide (XLEN=64, NREGS=16).
// Expectations for same-cycle write/read follow DECODE_WB_BYPASS_EN.
module tb_decode_stage_param;
    import decode_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        valid;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;
    exp_t q32[$];
    exp_t q64[$];

    decode_stage_param_if #(.XLEN(32), .NREGS(32)) if32 ();
    decode_stage_param_if #(.XLEN(64), .NREGS(16)) if64 ();

    decode_stage_param #(.XLEN(32), .NREGS(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32)
    );

    decode_stage_param #(.XLEN(64), .NREGS(16)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic v, input logic [63:0] rd1,
                                input logic [63:0] rd2, input logic [63:0] imm,
                                input logic [63:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd);
        exp_t e;
        e.name = n; e.valid = v; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.pc = pc; e.pc4 = pc + 64'd4; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        return e;
    endfunction

    function automatic exp_t bubble(input string n);
        exp_t e;
        e = mk(n, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        e.pc4 = 64'd0;
        return e;
    endfunction

    task automatic setD(input bit sel, input logic [31:0] instr, input imm_src_t src,
                        input logic [63:0] pc, input logic v);
        if (sel) begin
            if64.InstrD = instr; if64.ImmSrcD = src; if64.ValidD = v;
            if64.PCD = pc; if64.PCPlus4D = pc + 64'd4;
        end else begin
            if32.InstrD = instr; if32.ImmSrcD = src; if32.ValidD = v;
            if32.PCD = pc[31:0]; if32.PCPlus4D = pc[31:0] + 32'd4;
        end
    endtask

    task automatic setW(input bit sel, input logic we, input logic [4:0] rdw,
                        input logic [63:0] res);
        if (sel) begin
            if64.RegWriteW = we; if64.RdW = rdw[3:0]; if64.ResultW = res;
        end else begin
            if32.RegWriteW = we; if32.RdW = rdw; if32.ResultW = res[31:0];
        end
    endtask

    task automatic setC(input bit sel, input logic stall, input logic flush);
        if (sel) begin
            if64.StallE = stall; if64.FlushE = flush;
        end else begin
            if32.StallE = stall; if32.FlushE = flush;
        end
    endtask

    // One clock: the expected post-edge state is queued for the monitor.
    task automatic applyStimulus(input bit sel, input exp_t e);
        @(posedge clk);
        if (sel) q64.push_back(e);
        else     q32.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input string dut, input exp_t g, input exp_t e);
        nChecks++;
        if (g.valid !== e.valid || g.rd1 !== e.rd1 || g.rd2 !== e.rd2 ||
            g.imm !== e.imm || g.pc !== e.pc || g.pc4 !== e.pc4 ||
            g.rs1 !== e.rs1 || g.rs2 !== e.rs2 || g.rd !== e.rd) begin
            nFails++;
            $display("[TB] FAIL %s/%s: got v=%b rd1=%h rd2=%h imm=%h pc=%h pc4=%h rs1=%0d rs2=%0d rd=%0d | want v=%b rd1=%h rd2=%h imm=%h pc=%h pc4=%h rs1=%0d rs2=%0d rd=%0d",
                     dut, e.name, g.valid, g.rd1, g.rd2, g.imm, g.pc, g.pc4, g.rs1, g.rs2, g.rd,
                     e.valid, e.rd1, e.rd2, e.imm, e.pc, e.pc4, e.rs1, e.rs2, e.rd);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin : mon32
        exp_t e;
        exp_t g;
        if (q32.size() > 0) begin
            e = q32.pop_front();
            g.name = e.name; g.valid = if32.ValidE;
            g.rd1 = 64'(if32.RD1_E); g.rd2 = 64'(if32.RD2_E); g.imm = 64'(if32.ImmExtE);
            g.pc = 64'(if32.PCE); g.pc4 = 64'(if32.PCPlus4E);
            g.rs1 = if32.Rs1E; g.rs2 = if32.Rs2E; g.rd = if32.RdE;
            checkOutput("dut32", g, e);
        end
    end

    // Monitor for the 64-bit / 16-register instance.
    always @(negedge clk) begin : mon64
        exp_t e;
        exp_t g;
        if (q64.size() > 0) begin
            e = q64.pop_front();
            g.name = e.name; g.valid = if64.ValidE;
            g.rd1 = if64.RD1_E; g.rd2 = if64.RD2_E; g.imm = if64.ImmExtE;
            g.pc = if64.PCE; g.pc4 = if64.PCPlus4E;
            g.rs1 = 5'(if64.Rs1E); g.rs2 = 5'(if64.Rs2E); g.rd = 5'(if64.RdE);
            checkOutput("dut64", g, e);
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        nChecks = 0;
        nFails  = 0;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            setD(s[0], 32'h0, IMM_I, 64'h0, 1'b0);
            setW(s[0], 1'b0, 5'd0, 64'h0);
            setC(s[0], 1'b0, 1'b0);
        end

        // ---------------- 32-bit instance ----------------
        applyStimulus(0, bubble("reset"));
        rst = 1'b0;

        setD(0, 32'h00500093, IMM_I, 64'h100, 1'b1);
        applyStimulus(0, mk("addi_load", 1, 0, 0, 64'h5, 64'h100, 0, 5, 1));
        setD(0, 32'hFE000EE3, IMM_B, 64'h104, 1'b1);
        applyStimulus(0, mk("imm_B", 1, 0, 0, 64'hFFFF_FFFC, 64'h104, 0, 0, 29));
        setD(0, 32'h123450B7, IMM_U, 64'h108, 1'b1);
        applyStimulus(0, mk("imm_U", 1, 0, 0, 64'h1234_5000, 64'h108, 8, 3, 1));
        setD(0, 32'hFE112E23, IMM_S, 64'h10C, 1'b1);
        applyStimulus(0, mk("imm_S", 1, 0, 0, 64'hFFFF_FFFC, 64'h10C, 2, 1, 28));
        setD(0, 32'h008000EF, IMM_J, 64'h110, 1'b1);
        applyStimulus(0, mk("imm_J", 1, 0, 0, 64'h8, 64'h110, 0, 8, 1));
        setD(0, 32'hFFFFFFFF, imm_src_t'(3'd5), 64'h114, 1'b1);
        applyStimulus(0, mk("imm_code5", 1, 0, 0, 64'h0, 64'h114, 31, 31, 31));

        setW(0, 1'b1, 5'd3, 64'hDEAD_BEEF);
        setD(0, 32'h00018213, IMM_I, 64'h118, 1'b1);
        applyStimulus(0, mk("wr_rd_same_rs1", 1, BYP ? 64'hDEAD_BEEF : 64'h0, 0, 0, 64'h118, 3, 0, 4));
        setW(0, 1'b0, 5'd0, 64'h0);
        setD(0, 32'h00018213, IMM_I, 64'h11C, 1'b1);
        applyStimulus(0, mk("rd_after_wr_rs1", 1, 64'hDEAD_BEEF, 0, 0, 64'h11C, 3, 0, 4));
        setW(0, 1'b1, 5'd6, 64'h1234_5678);
        setD(0, 32'h00600333, IMM_I, 64'h120, 1'b1);
        applyStimulus(0, mk("wr_rd_same_rs2", 1, 0, BYP ? 64'h1234_5678 : 64'h0, 64'h6, 64'h120, 0, 6, 6));
        setW(0, 1'b0, 5'd0, 64'h0);
        applyStimulus(0, mk("rd_after_wr_rs2", 1, 0, 64'h1234_5678, 64'h6, 64'h120, 0, 6, 6));

        setW(0, 1'b1, 5'd0, 64'hFFFF_FFFF);
        setD(0, 32'h00000013, IMM_I, 64'h128, 1'b1);
        applyStimulus(0, mk("x0_wr_same", 1, 0, 0, 0, 64'h128, 0, 0, 0));
        setW(0, 1'b0, 5'd0, 64'h0);
        setD(0, 32'h00000013, IMM_I, 64'h12C, 1'b1);
        applyStimulus(0, mk("x0_rd_after", 1, 0, 0, 0, 64'h12C, 0, 0, 0));

        setD(0, 32'h00500093, IMM_I, 64'h200, 1'b1);
        applyStimulus(0, mk("stall_load", 1, 0, 0, 64'h5, 64'h200, 0, 5, 1));
        setC(0, 1'b1, 1'b0);
        setW(0, 1'b1, 5'd7, 64'hCAFE_F00D);
        for (int k = 0; k < 3; k++) begin
            setD(0, 32'h003002B3, IMM_I, 64'h204 + 64'(4 * k), 1'b0);
            applyStimulus(0, mk($sformatf("stall_hold%0d", k), 1, 0, 0, 64'h5, 64'h200, 0, 5, 1));
            setW(0, 1'b0, 5'd0, 64'h0);
        end
        setC(0, 1'b1, 1'b1);
        setW(0, 1'b1, 5'd9, 64'h0BAD_F00D);
        applyStimulus(0, bubble("flush_and_stall"));
        setC(0, 1'b0, 1'b0);
        setW(0, 1'b0, 5'd0, 64'h0);
        setD(0, 32'h00038413, IMM_I, 64'h300, 1'b0);
        applyStimulus(0, mk("wr_during_stall", 0, 64'hCAFE_F00D, 0, 0, 64'h300, 7, 0, 8));
        setD(0, 32'h00900533, IMM_I, 64'h304, 1'b1);
        applyStimulus(0, mk("wr_during_flush", 1, 0, 64'h0BAD_F00D, 64'h9, 64'h304, 0, 9, 10));

        setC(0, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(0, bubble("reset_mid_stall"));
        rst = 1'b0;
        setC(0, 1'b0, 1'b0);
        setD(0, 32'h00718233, IMM_I, 64'h308, 1'b1);
        applyStimulus(0, mk("rf_cleared", 1, 0, 0, 64'h7, 64'h308, 3, 7, 4));

        // ---------------- 64-bit, 16-register instance ----------------
        rst = 1'b1;
        applyStimulus(1, bubble("reset64"));
        rst = 1'b0;
        setW(1, 1'b1, 5'd15, 64'h8000_0000_0000_0001);
        setD(1, 32'h00000013, IMM_I, 64'h1_0000_0000, 1'b1);
        applyStimulus(1, mk("wr_x15", 1, 0, 0, 0, 64'h1_0000_0000, 0, 0, 0));
        setW(1, 1'b0, 5'd0, 64'h0);
        setD(1, 32'h00F000B3, IMM_I, 64'h1_0000_0004, 1'b1);
        applyStimulus(1, mk("rd_x15", 1, 0, 64'h8000_0000_0000_0001, 64'hF, 64'h1_0000_0004, 0, 15, 1));
        setD(1, 32'h01F000B3, IMM_I, 64'h1_0000_0008, 1'b1);
        applyStimulus(1, mk("rs2_msb_ignored", 1, 0, 64'h8000_0000_0000_0001, 64'h1F, 64'h1_0000_0008, 0, 15, 1));
        setD(1, 32'h80000013, IMM_I, 64'h1_0000_000C, 1'b1);
        applyStimulus(1, mk("imm_I_neg64", 1, 0, 0, 64'hFFFF_FFFF_FFFF_F800, 64'h1_0000_000C, 0, 0, 0));
        setD(1, 32'h800000B7, IMM_U, 64'h1_0000_0010, 1'b1);
        applyStimulus(1, mk("imm_U_neg64", 1, 0, 0, 64'hFFFF_FFFF_8000_0000, 64'h1_0000_0010, 0, 0, 1));
        setC(1, 1'b0, 1'b1);
        applyStimulus(1, bubble("flush64"));
        setC(1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        nChecks++;
        if (q32.size() != 0 || q64.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending entries, required 0/0",
                     q32.size(), q64.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
